fe_ingress_arbiter: RTL
=======================

Name: fe_ingress_arbiter

Overview:
Sits directly downstream of the eight per-port MAC instances in the switch top. It consumes each MAC's frame-header word and packet length (mac_fe_data, mac_fe_pkt_len) under the arb_valid/arb_mac_rdy handshake. It selects one port per transfer by round-robin, filters illegal lengths, and presents a single registered stream to the forwarding engine. It also keeps forwarded and dropped counters.

Parameters:
NUM_PORTS, 8, number of MAC ports arbitrated
DATA_W, 256, width of mac_fe_data per port
LEN_W, 12, width of mac_fe_pkt_len per port
MIN_LEN, 64, smallest legal packet length (bytes, inclusive)
MAX_LEN, 1518, largest legal packet length (bytes, inclusive)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
arb_valid  in  NUM_PORTS  bit i: MAC i holds a header/length pending
mac_fe_data  in  NUM_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W]
mac_fe_pkt_len  in  NUM_PORTS*LEN_W  port i at [i*LEN_W +: LEN_W]
arb_mac_rdy  out  NUM_PORTS  bit i: port i accepted this cycle; at most one bit set
fe_valid  out  1  output register holds a valid entry
fe_data  out  DATA_W  forwarded header word
fe_pkt_len  out  LEN_W  forwarded packet length
fe_src_port  out  $clog2(NUM_PORTS)  index of the originating MAC
fe_rdy  in  1  forwarding engine accepts when fe_valid & fe_rdy
fwd_cnt  out  CNT_W  packets forwarded (saturating)
drop_cnt  out  CNT_W  packets dropped for illegal length (saturating)

Behaviour:
- Reset (clk edge with reset=1):
  - fe_valid=0, fe_data=0, fe_pkt_len=0, fe_src_port=0.
  - fwd_cnt=0, drop_cnt=0.
  - rr_ptr=NUM_PORTS-1, so port 0 has first priority.
  - arb_mac_rdy is 0 while reset=1 (gated combinationally).
- Output FSM, two states:
  - EMPTY (fe_valid=0).
  - FULL (fe_valid=1).
- can_accept = ~fe_valid | fe_rdy.
- Grant selection, combinational:
  - Scan arb_valid starting at (rr_ptr+1) mod NUM_PORTS, wrapping upward.
  - The first set bit is gnt (one-hot), with index gidx.
  - If arb_valid==0, gnt=0.
- arb_mac_rdy = gnt & {NUM_PORTS{can_accept}}.
  - This is combinational from arb_valid/fe_rdy/state.
  - MACs must hold data/length stable while arb_valid=1 until they see arb_mac_rdy.
- Transfer on port i: arb_valid[i] & arb_mac_rdy[i] at a clk edge. On transfer:
  - rr_ptr <= gidx, updated for both forwarded and dropped packets.
  - Legal length (MIN_LEN <= len <= MAX_LEN):
    - Capture data, len and gidx into the output register; fe_valid<=1.
    - fwd_cnt increments.
    - Latency: handshake cycle N, so fe_valid=1 at cycle N+1.
  - Illegal length:
    - Not forwarded; drop_cnt increments.
    - fe_valid <= fe_valid & ~fe_rdy, i.e. normal drain.
- Output drain: if fe_valid & fe_rdy and there is no legal transfer the same cycle, fe_valid<=0.
  - A simultaneous drain and legal capture keeps fe_valid=1 with the new contents.
  - This gives full throughput: one packet per cycle when fe_rdy is held at 1.
- FULL with fe_rdy=0:
  - arb_mac_rdy=0 and rr_ptr is unchanged.
  - fe_data, fe_pkt_len and fe_src_port are held stable.
- fwd_cnt and drop_cnt saturate at 2^CNT_W-1 and never wrap.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 grants.
- Reset asserted mid-packet or while FULL: the entry is discarded and the block returns to reset values on that edge.
- Upstream handshake: arb_valid deasserting without a handshake is legal. That port simply drops out of the scan; no error is flagged.

Test Plan:
- Single request: after reset, arb_valid=8'h04, len=100, fe_rdy=1 -> arb_mac_rdy=8'h04 that cycle; next cycle fe_valid=1, fe_src_port=2, fe_pkt_len=100; fwd_cnt=1.
- Round-robin: arb_valid=8'hFF held, all len=64, fe_rdy=1 -> grants on ports 0,1,...,7,0 on consecutive cycles; fe_valid stays 1; after 8 cycles fwd_cnt=8.
- Backpressure: fe_valid=1 with fe_rdy=0 for 5 cycles while arb_valid=8'h11 -> arb_mac_rdy=0 and outputs stable; on fe_rdy=1, port 0 is granted; the following grant goes to port 4.
- Length filter: port 3 lengths 63, 64, 1518, 1519 in turn -> all four acknowledged; only 64 and 1518 appear on fe_*; drop_cnt=2, fwd_cnt=2.
- Saturation: CNT_W=4, 20 legal packets -> fwd_cnt stops at 15.
- Reset mid-operation: reset=1 while fe_valid=1 and arb_valid=8'hFF -> next cycle fe_valid=0, counters 0, arb_mac_rdy=0; first grant after release goes to port 0.

Source files
------------

// File: rtl/fe_ingress_arbiter.sv
// Round-robin ingress arbiter: picks one MAC port per transfer, drops illegal
// lengths, and drives a single registered stream with saturating statistics.
module fe_ingress_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 12,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        arb_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] mac_fe_data,
  input  logic [NUM_PORTS*LEN_W-1:0]  mac_fe_pkt_len,
  output logic [NUM_PORTS-1:0]        arb_mac_rdy,
  output logic                        fe_valid,
  output logic [DATA_W-1:0]           fe_data,
  output logic [LEN_W-1:0]            fe_pkt_len,
  output logic [IDX_W-1:0]            fe_src_port,
  input  logic                        fe_rdy,
  output logic [CNT_W-1:0]            fwd_cnt,
  output logic [CNT_W-1:0]            drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [DATA_W-1:0]  data_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   src_q;
  logic [CNT_W-1:0]   fwd_q, drop_q;

  logic [DATA_W-1:0]  port_data [NUM_PORTS];
  logic [LEN_W-1:0]   port_len  [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign port_data[g] = mac_fe_data[g*DATA_W +: DATA_W];
    assign port_len[g]  = mac_fe_pkt_len[g*LEN_W +: LEN_W];
  end

  logic               gnt_found;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   scan_idx;
  logic               can_accept, xfer, legal, capture, drop;

  // Scan upward from the port after the last winner; the first requester wins.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    gnt_found = 1'b0;
    gidx      = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!gnt_found && arb_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gidx      = scan_idx;
      end
    end
  end

  assign fe_valid    = (state_q == FULL);
  assign can_accept  = ~fe_valid | fe_rdy;
  assign arb_mac_rdy = (gnt_found && can_accept && !reset) ? (NUM_PORTS'(1) << gidx) : '0;
  assign xfer        = |arb_mac_rdy;
  assign legal       = (port_len[gidx] >= LEN_W'(MIN_LEN)) && (port_len[gidx] <= LEN_W'(MAX_LEN));
  assign capture     = xfer & legal;
  assign drop        = xfer & ~legal;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (capture) state_d = FULL;
      FULL:  if (!capture && fe_rdy) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
      data_q   <= '0;
      len_q    <= '0;
      src_q    <= '0;
      fwd_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) rr_ptr_q <= gidx;
      if (capture) begin
        data_q <= port_data[gidx];
        len_q  <= port_len[gidx];
        src_q  <= gidx;
      end
      // Statistics stick at all-ones rather than wrapping.
      if (capture && fwd_q != '1) fwd_q <= fwd_q + 1'b1;
      if (drop && drop_q != '1)   drop_q <= drop_q + 1'b1;
    end
  end

  assign fe_data     = data_q;
  assign fe_pkt_len  = len_q;
  assign fe_src_port = src_q;
  assign fwd_cnt     = fwd_q;
  assign drop_cnt    = drop_q;

endmodule
